// File: rtl/md_unit.sv
// ----------------------------------------------------------------------------
// md_unit
//   Iterative multiply/divide unit that owns the HI/LO registers.
//   mult/multu use shift-add, div/divu use restoring division, one bit per
//   cycle. mthi/mtlo write HI/LO in a single cycle. busy stays high while an
//   operation is in flight so that dependent instructions stall in EX.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      asynchronous reset, active low
//   md_valid  in   1      EX stage holds a live instruction
//   md_func   in   3      0 none, 1 mthi, 2 mtlo, 3 mult, 4 div, 5-7 none
//   md_sign   in   1      1 signed, 0 unsigned (mult/div only)
//   src_a     in   WIDTH  rs operand
//   src_b     in   WIDTH  rt operand
//   busy      out  1      operation in flight, HI/LO not yet final
//   hi        out  WIDTH  HI register
//   lo        out  WIDTH  LO register
// ----------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_valid,
    input  logic [2:0]       md_func,
    input  logic             md_sign,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_e;

    typedef enum logic [2:0] {
        FN_NONE = 3'd0,
        FN_MTHI = 3'd1,
        FN_MTLO = 3'd2,
        FN_MULT = 3'd3,
        FN_DIV  = 3'd4
    } func_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;     // multiply accumulator: {partial, multiplier}
    logic [WIDTH:0]     rem;     // partial remainder, one spare bit for borrow
    logic [WIDTH-1:0]   quo;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   op_b;    // |b|
    logic [WIDTH-1:0]   a_raw;   // original dividend, returned on divide by zero
    logic               sign_q;  // result/quotient negative
    logic               sign_r;  // remainder negative
    logic               op_div;
    logic               div0;

    logic               sign_a_in;
    logic               sign_b_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Most-negative input negates to itself; read as unsigned it is the
    // correct magnitude, so no extra bit is needed.
    always_comb begin
        sign_a_in = md_sign & src_a[WIDTH-1];
        sign_b_in = md_sign & src_b[WIDTH-1];
        mag_a_in  = sign_a_in ? -src_a : src_a;
        mag_b_in  = sign_b_in ? -src_b : src_b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_b : {WIDTH{1'b0}})};
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {2'b00, op_b};
        prod_fix  = sign_q ? -acc : acc;
        q_fix     = sign_q ? -quo : quo;
        r_fix     = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            op_b   <= '0;
            a_raw  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            op_div <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_valid) begin
                        case (md_func)
                            FN_MTHI: hi <= src_a;
                            FN_MTLO: lo <= src_a;
                            FN_MULT: begin
                                acc    <= {{WIDTH{1'b0}}, mag_a_in};
                                op_b   <= mag_b_in;
                                sign_q <= sign_a_in ^ sign_b_in;
                                sign_r <= 1'b0;
                                op_div <= 1'b0;
                                div0   <= 1'b0;
                                cnt    <= CW'(WIDTH - 1);
                                state  <= MUL;
                            end
                            FN_DIV: begin
                                rem    <= '0;
                                quo    <= mag_a_in;
                                op_b   <= mag_b_in;
                                a_raw  <= src_a;
                                sign_q <= sign_a_in ^ sign_b_in;
                                sign_r <= sign_a_in;
                                op_div <= 1'b1;
                                div0   <= (src_b == '0);
                                cnt    <= CW'(WIDTH - 1);
                                state  <= DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                DIV: begin
                    // Borrow out of the widened subtraction means restore.
                    if (div_diff[WIDTH+1]) begin
                        rem <= div_shift[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= div_diff[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    if (op_div) begin
                        if (div0) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// ----------------------------------------------------------------------------
// tb_md_unit
//   Directed bench for md_unit with hand-computed expected HI/LO values and
//   busy-length checks. Inputs change on the falling edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nchecks;
    int nerrors;
    int n;
    int m;

    md_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_func  (md_func),
        .md_sign  (md_sign),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic issue(input logic [2:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_func  = f;
        md_sign  = s;
        src_a    = a;
        src_b    = b;
        @(negedge clk);
        md_valid = 1'b0;
        md_func  = 3'd0;
        md_sign  = 1'b0;
        src_a    = '0;
        src_b    = '0;
    endtask

    // Counts falling edges with busy high; bounded so a stuck FSM still ends.
    task automatic run_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        nchecks  = 0;
        nerrors  = 0;
        reset    = 1'b0;
        md_valid = 1'b0;
        md_func  = 3'd0;
        md_sign  = 1'b0;
        src_a    = '0;
        src_b    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // mthi/mtlo, then reset mid-divide
        issue(3'd1, 1'b0, 32'h55, 32'h0);
        check("mthi_hi", hi, 32'h55);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        issue(3'd2, 1'b0, 32'h66, 32'h0);
        check("mtlo_lo", lo, 32'h66);
        issue(3'd4, 1'b1, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        check("div_busy_t10", {31'b0, busy}, 32'd1);
        check("div_hold_hi", hi, 32'h55);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(3'd1, 1'b0, 32'h1234, 32'h0);
        check("post_rst_mthi", hi, 32'h0000_1234);

        // multu max*max
        issue(3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_keep_hi", hi, 32'h0000_1234);
        run_busy(n);
        check("multu_busy_len", n, 32'd33);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // signed mult and div
        issue(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7);
        run_busy(n);
        check("mult_busy_len", n, 32'd33);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_busy(n);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        // overflow and divide by zero
        issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy(n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        issue(3'd4, 1'b0, 32'd5, 32'd0);
        run_busy(n);
        check("divu0_busy_len", n, 32'd33);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd5);
        issue(3'd4, 1'b1, 32'hFFFF_FFF7, 32'd0);
        run_busy(n);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'hFFFF_FFF7);

        // Commands held while busy are ignored
        issue(3'd3, 1'b1, 32'd3, 32'd5);
        md_valid = 1'b1;
        md_func  = 3'd3;
        md_sign  = 1'b0;
        src_a    = 32'd2;
        src_b    = 32'd2;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        md_func = 3'd2;
        src_a   = 32'hAA;
        src_b   = 32'd0;
        check("held_lo_keep", lo, 32'hFFFF_FFFF);
        run_busy(m);
        check("held_busy_len", n + m, 32'd33);
        check("held_mult_hi", hi, 32'd0);
        check("held_mult_lo", lo, 32'd15);
        @(negedge clk);
        check("held_mtlo_lo", lo, 32'hAA);
        check("held_mtlo_busy", {31'b0, busy}, 32'd0);
        md_valid = 1'b0;
        md_func  = 3'd0;
        src_a    = '0;

        // divu 100/7, then reserved function codes
        issue(3'd4, 1'b0, 32'd100, 32'd7);
        run_busy(n);
        check("divu_busy_len", n, 32'd33);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        md_valid = 1'b1;
        md_func  = 3'd6;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'd1;
        repeat (3) @(negedge clk);
        md_func = 3'd0;
        repeat (2) @(negedge clk);
        check("rsvd_busy", {31'b0, busy}, 32'd0);
        check("rsvd_lo", lo, 32'd14);
        check("rsvd_hi", hi, 32'd2);
        md_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
